// File: rtl/snoop_responder.sv
// Snoop side of one cache on the 15-bit snooping bus: watches resolved bus
// transactions, applies MSI transitions to a 4-line direct-mapped store and
// drives a write-back word when a remote miss hits a local Modified line.
// Also owns the processor-side write port of the line store.
module snoop_responder #(
  parameter int unsigned RESP_HOLD = 2,
  parameter int unsigned MY_ID     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] bus_in,
  input  logic        bus_strobe,
  input  logic        own_emit,
  input  logic        lcl_wr_en,
  input  logic [2:0]  lcl_tag,
  input  logic [1:0]  lcl_state,
  input  logic [7:0]  lcl_data,
  output logic        lcl_wr_nack,
  output logic [14:0] bus_R_OUT,
  output logic        snoop_busy,
  output logic        proto_err,
  output logic        overrun
);

  localparam int unsigned TAG_W  = 3;
  localparam int unsigned MSG_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = 15;
  localparam int unsigned LINES  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ST_W   = 2;
  localparam int unsigned CNT_W  = 3;

  localparam logic [MSG_W-1:0] MSG_READ_MISS  = 3'b001;
  localparam logic [MSG_W-1:0] MSG_WRITE_MISS = 3'b010;
  localparam logic [MSG_W-1:0] MSG_INVALIDATE = 3'b011;
  localparam logic [MSG_W-1:0] MSG_WRITE_BACK = 3'b100;

  localparam logic [ST_W-1:0] LS_I = 2'b00;
  localparam logic [ST_W-1:0] LS_S = 2'b01;
  localparam logic [ST_W-1:0] LS_M = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2
  } fsm_t;

  fsm_t               state_q, state_d;
  logic [TAG_W-1:0]   cap_tag_q, cap_tag_d;
  logic [MSG_W-1:0]   cap_msg_q, cap_msg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  resp_q, resp_d;
  logic               nack_q, nack_d;
  logic               perr_q, perr_d;
  logic               ovr_q, ovr_d;

  logic [TAG_W-1:0]   line_tag_q  [LINES];
  logic [TAG_W-1:0]   line_tag_d  [LINES];
  logic [ST_W-1:0]    line_st_q   [LINES];
  logic [ST_W-1:0]    line_st_d   [LINES];
  logic [DATA_W-1:0]  line_data_q [LINES];
  logic [DATA_W-1:0]  line_data_d [LINES];

  logic [IDX_W-1:0]   snp_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               snp_hit;
  logic               strobe_acc;
  logic [ST_W-1:0]    wr_state;

  // Only tag and message of the bus word matter here; the rest is deliberately unused.
  logic unused_bits;
  assign unused_bits = ^{bus_in[8:0], 1'(MY_ID)};

  // Lookup address, hit detection and sanitised local write state.
  assign snp_idx    = cap_tag_q[IDX_W-1:0];
  assign wr_idx     = lcl_tag[IDX_W-1:0];
  assign snp_hit    = (line_st_q[snp_idx] != LS_I) && (line_tag_q[snp_idx] == cap_tag_q);
  assign strobe_acc = bus_strobe && !own_emit;
  assign wr_state   = (lcl_state == 2'b11) ? LS_I : lcl_state;

  // Next-state, line-store update and response decision.
  always_comb begin
    state_d     = state_q;
    cap_tag_d   = cap_tag_q;
    cap_msg_d   = cap_msg_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    nack_d      = 1'b0;
    perr_d      = perr_q;
    ovr_d       = ovr_q;
    line_tag_d  = line_tag_q;
    line_st_d   = line_st_q;
    line_data_d = line_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (strobe_acc) begin
          cap_tag_d = bus_in[14:12];
          cap_msg_d = bus_in[11:9];
          state_d   = ST_LOOKUP;
          if (lcl_wr_en) nack_d = 1'b1;
        end else if (lcl_wr_en) begin
          line_tag_d[wr_idx]  = lcl_tag;
          line_st_d[wr_idx]   = wr_state;
          line_data_d[wr_idx] = lcl_data;
        end
      end

      ST_LOOKUP: begin
        if (strobe_acc) ovr_d  = 1'b1;
        if (lcl_wr_en)  nack_d = 1'b1;
        state_d = ST_IDLE;
        if (snp_hit) begin
          unique case (cap_msg_q)
            MSG_READ_MISS: begin
              if (line_st_q[snp_idx] == LS_M) begin
                line_st_d[snp_idx] = LS_S;
                state_d            = ST_RESPOND;
              end
            end
            MSG_WRITE_MISS: begin
              if (line_st_q[snp_idx] == LS_M) state_d = ST_RESPOND;
              line_st_d[snp_idx] = LS_I;
            end
            MSG_INVALIDATE: begin
              if (line_st_q[snp_idx] == LS_M) perr_d = 1'b1;
              line_st_d[snp_idx] = LS_I;
            end
            default: ;
          endcase
        end
        if (state_d == ST_RESPOND) begin
          resp_d = {cap_tag_q, MSG_WRITE_BACK, 1'b1, line_data_q[snp_idx]};
          cnt_d  = CNT_W'(RESP_HOLD);
        end
      end

      ST_RESPOND: begin
        if (strobe_acc) ovr_d  = 1'b1;
        if (lcl_wr_en)  nack_d = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          resp_d  = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, line store and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cap_tag_q <= '0;
      cap_msg_q <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      nack_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        line_tag_q[i]  <= '0;
        line_st_q[i]   <= LS_I;
        line_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cap_tag_q   <= cap_tag_d;
      cap_msg_q   <= cap_msg_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      nack_q      <= nack_d;
      perr_q      <= perr_d;
      ovr_q       <= ovr_d;
      line_tag_q  <= line_tag_d;
      line_st_q   <= line_st_d;
      line_data_q <= line_data_d;
    end
  end

  assign bus_R_OUT   = resp_q;
  assign lcl_wr_nack = nack_q;
  assign proto_err   = perr_q;
  assign overrun     = ovr_q;
  assign snoop_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snoop_responder.sv
// Bench for snoop_responder: directed cycle vectors plus a randomized run
// checked against a transaction-level reference model.
module tb_snoop_responder;

  localparam int unsigned HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] bus_in;
  logic        bus_strobe;
  logic        own_emit;
  logic        lcl_wr_en;
  logic [2:0]  lcl_tag;
  logic [1:0]  lcl_state;
  logic [7:0]  lcl_data;
  logic        lcl_wr_nack;
  logic [14:0] bus_R_OUT;
  logic        snoop_busy;
  logic        proto_err;
  logic        overrun;

  always #5 clk = ~clk;

  snoop_responder #(.RESP_HOLD(HOLD), .MY_ID(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .bus_strobe (bus_strobe),
    .own_emit   (own_emit),
    .lcl_wr_en  (lcl_wr_en),
    .lcl_tag    (lcl_tag),
    .lcl_state  (lcl_state),
    .lcl_data   (lcl_data),
    .lcl_wr_nack(lcl_wr_nack),
    .bus_R_OUT  (bus_R_OUT),
    .snoop_busy (snoop_busy),
    .proto_err  (proto_err),
    .overrun    (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst_n, stb, own;
    logic [2:0]  tag, msg;
    logic        we;
    logic [2:0]  ltag;
    logic [1:0]  lst;
    logic [7:0]  ldat;
    logic [14:0] eout;
    logic        ebusy, enack, eperr, eovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic s, logic o, logic [2:0] t, logic [2:0] m,
                              logic w, logic [2:0] lt, logic [1:0] ls, logic [7:0] ld,
                              logic [14:0] eo, logic eb, logic en, logic ep, logic ev);
    vec_t v;
    v.rst_n = r; v.stb = s; v.own = o; v.tag = t; v.msg = m;
    v.we = w; v.ltag = lt; v.lst = ls; v.ldat = ld;
    v.eout = eo; v.ebusy = eb; v.enack = en; v.eperr = ep; v.eovr = ev;
    tbl.push_back(v);
  endfunction

  localparam logic [2:0] RM = 3'd1, WM = 3'd2, INV = 3'd3, WB = 3'd4, RSV = 3'd7;

  function automatic void build_table();
    //   rst stb own tag     msg  we ltag    st     data   exp_out   bsy nak per ovr
    add(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0); // 0 reset
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 1, 3'd5, 2'd2, 8'hA5, 15'h0000, 0, 0, 0, 0); // line1=M 101 A5
    add(1, 1, 0, 3'd5, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0); // READ_MISS 101
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h59A5, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h59A5, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0);
    add(1, 1, 0, 3'd5, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0); // line1 now S
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0); // no response
    add(1, 0, 0, 3'd0, 3'd0, 1, 3'd2, 2'd2, 8'h3C, 15'h0000, 0, 0, 0, 0); // 9 line2=M 010 3C
    add(1, 1, 0, 3'd2, WM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h293C, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h293C, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0);
    add(1, 1, 0, 3'd2, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0); // line2 now I
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 1, 3'd2, 2'd2, 8'h3C, 15'h0000, 0, 0, 0, 0); // 16 line2=M again
    add(1, 1, 0, 3'd6, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0); // tag miss
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0);
    add(1, 1, 1, 3'd6, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0); // own emit
    add(1, 1, 1, 3'd2, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0); // own emit, would hit
    add(1, 1, 0, 3'd2, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0); // 21 hit M
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h293C, 1, 0, 0, 0);
    add(1, 1, 0, 3'd5, WM,   1, 3'd2, 2'd0, 8'h00, 15'h293C, 1, 1, 0, 1); // collisions
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 1);
    add(1, 1, 0, 3'd2, WM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 1); // 25 line2 is S
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 1); // S write miss: silent
    add(1, 0, 0, 3'd0, 3'd0, 1, 3'd7, 2'd2, 8'h77, 15'h0000, 0, 0, 0, 1); // line3=M 111
    add(1, 1, 0, 3'd7, INV,  0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 1);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 1, 1); // proto_err
    add(1, 1, 0, 3'd7, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 1, 1); // 30 line3 now I
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 1, 1);
    add(1, 1, 0, 3'd3, RM,   1, 3'd3, 2'd2, 8'h11, 15'h0000, 1, 1, 1, 1); // write vs strobe
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 1, 1);
    add(1, 1, 0, 3'd3, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 1, 1); // write was dropped
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 1, 1); // 35
    add(1, 0, 0, 3'd0, 3'd0, 1, 3'd1, 2'd2, 8'hF0, 15'h0000, 0, 0, 1, 1); // line1=M 001 F0
    add(1, 1, 0, 3'd1, RSV,  0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 1, 1); // reserved msg
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 1, 1);
    add(1, 1, 0, 3'd1, WB,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 1, 1); // write-back msg
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 1, 1); // 40
    add(1, 1, 0, 3'd1, RM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 1, 1); // still M
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h19F0, 1, 0, 1, 1);
    add(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0); // reset mid-response
    add(1, 1, 0, 3'd1, WM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0); // 45 lines cleared
    add(1, 0, 0, 3'd0, 3'd0, 1, 3'd4, 2'd3, 8'h55, 15'h0000, 0, 0, 0, 0); // state 11 -> I
    add(1, 1, 0, 3'd4, WM,   0, 3'd0, 2'd0, 8'h00, 15'h0000, 1, 0, 0, 0);
    add(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 2'd0, 8'h00, 15'h0000, 0, 0, 0, 0);
  endfunction

  // ---------------- reference model ----------------
  int          m_st[4];
  int          m_tag[4];
  int          m_data[4];
  int unsigned plan[$];
  int unsigned m_out;
  bit          m_busy, m_nack, m_perr, m_ovr, perr_pend;

  // Decides the whole transaction at acceptance time; outputs then replay from plan.
  task automatic model_step();
    int t, g, i;
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin m_st[k] = 0; m_tag[k] = 0; m_data[k] = 0; end
      plan.delete();
      m_out = 0; m_busy = 0; m_nack = 0; m_perr = 0; m_ovr = 0; perr_pend = 0;
      return;
    end
    acc    = bus_strobe && !own_emit;
    m_nack = 0;
    if (!m_busy) begin
      if (acc) begin
        t = int'(bus_in[14:12]);
        g = int'(bus_in[11:9]);
        i = t % 4;
        if (m_st[i] != 0 && m_tag[i] == t) begin
          if (g == 1 && m_st[i] == 2) begin
            m_st[i] = 1;
            repeat (HOLD) plan.push_back((t << 12) + (4 << 9) + 256 + m_data[i]);
          end else if (g == 2) begin
            if (m_st[i] == 2) repeat (HOLD) plan.push_back((t << 12) + (4 << 9) + 256 + m_data[i]);
            m_st[i] = 0;
          end else if (g == 3) begin
            if (m_st[i] == 2) perr_pend = 1;
            m_st[i] = 0;
          end
        end
        m_busy = 1;
        m_out  = 0;
        if (lcl_wr_en) m_nack = 1;
      end else if (lcl_wr_en) begin
        i = int'(lcl_tag) % 4;
        m_tag[i]  = int'(lcl_tag);
        m_st[i]   = (lcl_state == 2'd3) ? 0 : int'(lcl_state);
        m_data[i] = int'(lcl_data);
      end
    end else begin
      if (acc) m_ovr = 1;
      if (lcl_wr_en) m_nack = 1;
      if (perr_pend) begin m_perr = 1; perr_pend = 0; end
      if (plan.size() > 0) m_out = plan.pop_front();
      else begin m_out = 0; m_busy = 0; end
    end
  endtask

  initial begin
    rst_n = 1'b0; bus_in = '0; bus_strobe = 1'b0; own_emit = 1'b0;
    lcl_wr_en = 1'b0; lcl_tag = '0; lcl_state = '0; lcl_data = '0;

    build_table();
    foreach (tbl[n]) begin
      rst_n      = tbl[n].rst_n;
      bus_strobe = tbl[n].stb;
      own_emit   = tbl[n].own;
      bus_in     = {tbl[n].tag, tbl[n].msg, 9'h0A5};
      lcl_wr_en  = tbl[n].we;
      lcl_tag    = tbl[n].ltag;
      lcl_state  = tbl[n].lst;
      lcl_data   = tbl[n].ldat;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", n),  16'(bus_R_OUT),   16'(tbl[n].eout));
      chk($sformatf("v%0d_busy", n), 16'(snoop_busy),  16'(tbl[n].ebusy));
      chk($sformatf("v%0d_nack", n), 16'(lcl_wr_nack), 16'(tbl[n].enack));
      chk($sformatf("v%0d_perr", n), 16'(proto_err),   16'(tbl[n].eperr));
      chk($sformatf("v%0d_ovr", n),  16'(overrun),     16'(tbl[n].eovr));
    end

    // Randomized phase, starting from reset so the model begins in step.
    rst_n = 1'b0; bus_strobe = 1'b0; lcl_wr_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) begin
        rst_n      = ($urandom_range(0, 299) != 0);
        bus_strobe = ($urandom_range(0, 3) == 0);
        own_emit   = ($urandom_range(0, 3) == 0);
        bus_in     = 15'($urandom);
        if ($urandom_range(0, 2) == 0) bus_in[11:9] = RM;
        lcl_wr_en  = ($urandom_range(0, 2) == 0);
        lcl_tag    = 3'($urandom);
        lcl_state  = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'($urandom);
        lcl_data   = 8'($urandom);
      end
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_out",  16'(bus_R_OUT),   16'(m_out));
      chk("rnd_busy", 16'(snoop_busy),  16'(m_busy));
      chk("rnd_nack", 16'(lcl_wr_nack), 16'(m_nack));
      chk("rnd_perr", 16'(proto_err),   16'(m_perr));
      chk("rnd_ovr",  16'(overrun),     16'(m_ovr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
